// File: rtl/network_flit_packet_arbiter_pkg.sv
// Flit framing definitions shared by the flit arbiter and the network-to-AXIS downsizer.
package noc_flit_pkg;

    localparam int FlitTypeSizeDefault = 2;

    localparam logic [1:0] FLIT_HEADER      = 2'b00;
    localparam logic [1:0] FLIT_BODY        = 2'b01;
    localparam logic [1:0] FLIT_TAIL        = 2'b10;
    localparam logic [1:0] FLIT_HEADER_TAIL = 2'b11;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // A flit that may legally open a packet.
    function automatic logic is_head_type(input logic [1:0] t);
        return (t == FLIT_HEADER) || (t == FLIT_HEADER_TAIL);
    endfunction

endpackage

// File: rtl/network_flit_packet_arbiter_rr_priority_picker.sv
// Round-robin picker: first requester found searching upward from rr_ptr+1, wrapping.
module rr_priority_picker #(
    parameter int NumInputs = 4,
    parameter int IdxW      = (NumInputs > 1) ? $clog2(NumInputs) : 1
) (
    input  logic [NumInputs-1:0] req_i,
    input  logic [IdxW-1:0]      rr_ptr_i,
    output logic [NumInputs-1:0] gnt_o,
    output logic [IdxW-1:0]      idx_o,
    output logic                 vld_o
);

    // Scan one full lap starting just after the last serviced input.
    always_comb begin
        int j;
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        j     = 0;
        for (int k = 1; k <= NumInputs; k++) begin
            j = (int'(rr_ptr_i) + k) % NumInputs;
            if (!vld_o && req_i[j]) begin
                vld_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IdxW'(j);
            end
        end
    end

endmodule

// File: rtl/network_flit_packet_arbiter.sv
// Packet-atomic round-robin merge of NoC ejection flit streams toward the downsizer.
module network_flit_packet_arbiter
    import noc_flit_pkg::*;
#(
    parameter int NumInputs    = 4,
    parameter int NocDataWidth = 64,
    parameter int flitTypeSize = FlitTypeSizeDefault,
    parameter int OutputReg    = 1
) (
    input  logic                              clk_noc,
    input  logic                              rst_noc,
    input  logic [NumInputs*flitTypeSize-1:0] s_flit_type_i,
    input  logic [NumInputs*NocDataWidth-1:0] s_flit_i,
    input  logic [NumInputs-1:0]              s_valid_i,
    output logic [NumInputs-1:0]              s_ready_o,
    output logic [flitTypeSize-1:0]           network_flit_type_o,
    output logic [NocDataWidth-1:0]           network_flit_o,
    output logic                              network_valid_o,
    input  logic                              network_ready_i,
    output logic [NumInputs-1:0]              grant_o,
    output logic                              locked_o,
    output logic                              err_o,
    output logic [NumInputs-1:0]              err_src_o
);

    localparam int IdxW = (NumInputs > 1) ? $clog2(NumInputs) : 1;

    arb_state_t                state;
    logic [IdxW-1:0]           owner;
    logic [IdxW-1:0]           rr_ptr;
    logic [NumInputs-1:0]      head_req;
    logic [NumInputs-1:0]      drop_req;
    logic [NumInputs-1:0]      pick_gnt;
    logic [NumInputs-1:0]      owner_oh;
    logic [IdxW-1:0]           pick_idx;
    logic                      pick_vld;
    logic [IdxW-1:0]           sel;
    logic [flitTypeSize-1:0]   sel_type;
    logic [NocDataWidth-1:0]   sel_flit;
    logic                      in_valid;
    logic                      stage_ready;
    logic                      xfer;
    logic                      frame_err;

    // Split valid inputs into packet openers (arbitration candidates) and stray flits to drop.
    always_comb begin
        head_req = '0;
        drop_req = '0;
        for (int i = 0; i < NumInputs; i++) begin
            if (s_valid_i[i]) begin
                if (is_head_type(s_flit_type_i[i*flitTypeSize +: 2])) begin
                    head_req[i] = 1'b1;
                end else if (state == ARB_IDLE) begin
                    drop_req[i] = 1'b1;
                end
            end
        end
    end

    rr_priority_picker #(
        .NumInputs (NumInputs),
        .IdxW      (IdxW)
    ) u_picker (
        .req_i    (head_req),
        .rr_ptr_i (rr_ptr),
        .gnt_o    (pick_gnt),
        .idx_o    (pick_idx),
        .vld_o    (pick_vld)
    );

    assign owner_oh    = NumInputs'(1) << owner;
    assign sel         = (state == ARB_LOCKED) ? owner : pick_idx;
    assign in_valid    = (state == ARB_LOCKED) ? s_valid_i[owner] : pick_vld;
    assign sel_type    = s_flit_type_i[sel*flitTypeSize +: flitTypeSize];
    assign sel_flit    = s_flit_i[sel*NocDataWidth +: NocDataWidth];
    assign stage_ready = (OutputReg != 0) ? (!network_valid_o || network_ready_i) : network_ready_i;
    assign xfer        = in_valid && stage_ready;
    assign frame_err   = (state == ARB_LOCKED) && xfer && is_head_type(sel_type[1:0]);

    // Only the selected source sees stage backpressure; stray flits in IDLE are always swallowed.
    always_comb begin
        s_ready_o = '0;
        if (state == ARB_LOCKED) begin
            s_ready_o[owner] = stage_ready;
        end else begin
            s_ready_o = drop_req;
            if (pick_vld) begin
                s_ready_o[pick_idx] = stage_ready;
            end
        end
    end

    // Packet lock FSM with registered grant/lock/error status; rr_ptr moves only at packet end.
    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            state     <= ARB_IDLE;
            owner     <= '0;
            rr_ptr    <= IdxW'(NumInputs - 1);
            grant_o   <= '0;
            locked_o  <= 1'b0;
            err_o     <= 1'b0;
            err_src_o <= '0;
        end else begin
            err_o     <= (|drop_req) || frame_err;
            err_src_o <= drop_req | (frame_err ? owner_oh : '0);
            case (state)
                ARB_IDLE: begin
                    if (xfer) begin
                        if (sel_type[1:0] == FLIT_HEADER) begin
                            state    <= ARB_LOCKED;
                            owner    <= pick_idx;
                            grant_o  <= pick_gnt;
                            locked_o <= 1'b1;
                        end else begin
                            rr_ptr <= pick_idx;
                        end
                    end
                end
                ARB_LOCKED: begin
                    if (xfer && ((sel_type[1:0] == FLIT_TAIL) ||
                                 (sel_type[1:0] == FLIT_HEADER_TAIL))) begin
                        state    <= ARB_IDLE;
                        rr_ptr   <= owner;
                        grant_o  <= '0;
                        locked_o <= 1'b0;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    generate
        if (OutputReg != 0) begin : g_oreg
            logic                    vld_p0;
            logic [flitTypeSize-1:0] type_p0;
            logic [NocDataWidth-1:0] flit_p0;

            // One-entry output slot; holds while the downsizer stalls a valid flit.
            always_ff @(posedge clk_noc or posedge rst_noc) begin
                if (rst_noc) begin
                    vld_p0  <= 1'b0;
                    type_p0 <= '0;
                    flit_p0 <= '0;
                end else if (stage_ready) begin
                    vld_p0 <= in_valid;
                    if (in_valid) begin
                        type_p0 <= sel_type;
                        flit_p0 <= sel_flit;
                    end
                end
            end

            assign network_valid_o     = vld_p0;
            assign network_flit_type_o = type_p0;
            assign network_flit_o      = flit_p0;
        end else begin : g_comb
            assign network_valid_o     = in_valid;
            assign network_flit_type_o = sel_type;
            assign network_flit_o      = sel_flit;
        end
    endgenerate

endmodule

// File: tb/tb_network_flit_packet_arbiter.sv
// Bench for network_flit_packet_arbiter: directed scenarios plus randomized traffic vs. a packet-level model.
module tb_network_flit_packet_arbiter;

    localparam int NI = 4;
    localparam int DW = 64;
    localparam int FW = 2;

    logic              clk_noc = 1'b0;
    logic              rst_noc = 1'b1;
    logic [NI*FW-1:0]  s_flit_type_i;
    logic [NI*DW-1:0]  s_flit_i;
    logic [NI-1:0]     s_valid_i;
    logic [NI-1:0]     s_ready_o;
    logic [FW-1:0]     network_flit_type_o;
    logic [DW-1:0]     network_flit_o;
    logic              network_valid_o;
    logic              network_ready_i;
    logic [NI-1:0]     grant_o;
    logic              locked_o;
    logic              err_o;
    logic [NI-1:0]     err_src_o;

    network_flit_packet_arbiter #(
        .NumInputs    (NI),
        .NocDataWidth (DW),
        .flitTypeSize (FW),
        .OutputReg    (1)
    ) dut (
        .clk_noc             (clk_noc),
        .rst_noc             (rst_noc),
        .s_flit_type_i       (s_flit_type_i),
        .s_flit_i            (s_flit_i),
        .s_valid_i           (s_valid_i),
        .s_ready_o           (s_ready_o),
        .network_flit_type_o (network_flit_type_o),
        .network_flit_o      (network_flit_o),
        .network_valid_o     (network_valid_o),
        .network_ready_i     (network_ready_i),
        .grant_o             (grant_o),
        .locked_o            (locked_o),
        .err_o               (err_o),
        .err_src_o           (err_src_o)
    );

    always #5 clk_noc = ~clk_noc;

    typedef struct packed {
        logic [1:0]  t;
        logic [63:0] d;
    } flit_t;

    flit_t       srcq [NI][$];
    flit_t       expq [$];
    flit_t       outlog [$];
    bit          m_locked;
    int          m_owner;
    int          m_rr;
    bit          m_err;
    logic [NI-1:0] m_errsrc;
    logic [NI-1:0] en;
    logic [NI-1:0] held;
    bit          rand_mode;
    int          total = 0;
    int          bad = 0;
    int          seq = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_head(input logic [1:0] t);
        return (t == 2'b00) || (t == 2'b11);
    endfunction

    task automatic model_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_rr     = NI - 1;
        m_err    = 1'b0;
        m_errsrc = '0;
        expq.delete();
    endtask

    task automatic push(input int i, input logic [1:0] t);
        flit_t f;
        f.t = t;
        f.d = {32'(i), 32'(seq)};
        seq++;
        srcq[i].push_back(f);
    endtask

    // Random packet of 1..4 flits, with an occasional corrupted type to exercise framing errors.
    task automatic gen(input int i);
        int len;
        logic [1:0] t;
        len = $urandom_range(1, 4);
        for (int k = 0; k < len; k++) begin
            if (len == 1)           t = 2'b11;
            else if (k == 0)        t = 2'b00;
            else if (k == len - 1)  t = 2'b10;
            else                    t = 2'b01;
            if ($urandom_range(0, 11) == 0) t = 2'($urandom_range(0, 3));
            push(i, t);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NI; i++) begin
            if (srcq[i].size() > 0 && en[i]) begin
                s_valid_i[i]            = 1'b1;
                s_flit_type_i[i*FW +: FW] = srcq[i][0].t;
                s_flit_i[i*DW +: DW]      = srcq[i][0].d;
            end else begin
                s_valid_i[i]            = 1'b0;
                s_flit_type_i[i*FW +: FW] = 2'($urandom_range(0, 3));
                s_flit_i[i*DW +: DW]      = {$urandom, $urandom};
            end
        end
    endtask

    // Compare all outputs with the model, then advance the model across the coming edge.
    task automatic check_cycle();
        logic [NI-1:0] er;
        logic [NI-1:0] eg;
        logic [NI-1:0] acc;
        int w;
        int j;
        bit sr;
        bit was_locked;
        flit_t f;
        sr = (expq.size() == 0) || network_ready_i;
        er = '0;
        w  = -1;
        if (!m_locked) begin
            for (int k = 1; k <= NI; k++) begin
                j = (m_rr + k) % NI;
                if (w < 0 && s_valid_i[j] && is_head(srcq[j][0].t)) w = j;
            end
            for (int i = 0; i < NI; i++)
                if (s_valid_i[i] && !is_head(srcq[i][0].t)) er[i] = 1'b1;
            if (w >= 0) er[w] = sr;
        end else begin
            er[m_owner] = sr;
        end
        eg = '0;
        if (m_locked) eg[m_owner] = 1'b1;
        chk("s_ready", 64'(s_ready_o), 64'(er));
        chk("locked", 64'(locked_o), 64'(m_locked));
        chk("grant", 64'(grant_o), 64'(eg));
        chk("err", 64'(err_o), 64'(m_err));
        chk("err_src", 64'(err_src_o), 64'(m_errsrc));
        chk("out_valid", 64'(network_valid_o), 64'(expq.size() > 0));
        if (expq.size() > 0 && network_valid_o) begin
            chk("out_type", 64'(network_flit_type_o), 64'(expq[0].t));
            chk("out_data", network_flit_o, expq[0].d);
        end
        if (network_valid_o && network_ready_i) begin
            f.t = network_flit_type_o;
            f.d = network_flit_o;
            outlog.push_back(f);
        end
        if (expq.size() > 0 && network_ready_i) void'(expq.pop_front());
        m_errsrc   = '0;
        was_locked = m_locked;
        acc        = s_valid_i & er;
        for (int i = 0; i < NI; i++) begin
            if (acc[i]) begin
                f = srcq[i][0];
                if (!was_locked) begin
                    if (!is_head(f.t)) begin
                        m_errsrc[i] = 1'b1;
                    end else begin
                        expq.push_back(f);
                        if (f.t == 2'b00) begin
                            m_locked = 1'b1;
                            m_owner  = i;
                        end else begin
                            m_rr = i;
                        end
                    end
                end else begin
                    expq.push_back(f);
                    if (f.t == 2'b10 || f.t == 2'b11) begin
                        m_locked = 1'b0;
                        m_rr     = i;
                    end
                    if (is_head(f.t)) m_errsrc[i] = 1'b1;
                end
                void'(srcq[i].pop_front());
            end
            held[i] = s_valid_i[i] && !acc[i];
        end
        m_err = |m_errsrc;
    endtask

    task automatic step();
        @(negedge clk_noc);
        check_cycle();
        @(posedge clk_noc);
        #1;
        if (rand_mode) begin
            network_ready_i = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NI; i++)
                if (!held[i]) en[i] = ($urandom_range(0, 3) != 0);
        end
        drive();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic check_log(input string nm, input int srcs[$]);
        chk({nm, "_len"}, 64'(outlog.size()), 64'(srcs.size()));
        for (int k = 0; k < srcs.size() && k < outlog.size(); k++)
            chk(nm, 64'(outlog[k].d[63:32]), 64'(srcs[k]));
    endtask

    initial begin
        s_valid_i       = '0;
        s_flit_type_i   = '0;
        s_flit_i        = '0;
        network_ready_i = 1'b1;
        en              = '1;
        held            = '0;
        rand_mode       = 1'b0;
        model_reset();

        #2;
        chk("rst_valid", 64'(network_valid_o), 64'(0));
        chk("rst_flit", network_flit_o, 64'(0));
        chk("rst_grant", 64'(grant_o), 64'(0));
        chk("rst_locked", 64'(locked_o), 64'(0));
        chk("rst_err", 64'({err_o, err_src_o}), 64'(0));
        #10 rst_noc = 1'b0;
        @(posedge clk_noc);
        #1;
        drive();

        // Two competing 3-flit packets from rr_ptr = 3: input 0 whole, then input 2.
        outlog.delete();
        push(0, 2'b00); push(0, 2'b01); push(0, 2'b10);
        push(2, 2'b00); push(2, 2'b01); push(2, 2'b10);
        drive();
        step();
        chk("t2_grant0", 64'(grant_o), 64'(4'b0001));
        steps(3);
        chk("t2_grant2", 64'(grant_o), 64'(4'b0100));
        steps(4);
        check_log("t2_order", '{0, 0, 0, 2, 2, 2});

        // Lone 3-flit packet on input 1.
        outlog.delete();
        push(1, 2'b00); push(1, 2'b01); push(1, 2'b10);
        drive();
        step();
        chk("t1_lock_c1", 64'({locked_o, grant_o}), 64'(5'b1_0010));
        chk("t1_first_out", 64'({network_valid_o, network_flit_type_o}), 64'(3'b100));
        step();
        chk("t1_lock_c2", 64'(locked_o), 64'(1));
        step();
        chk("t1_lock_c3", 64'(locked_o), 64'(0));
        step();
        check_log("t1_order", '{1, 1, 1});
        if (outlog.size() == 3)
            chk("t1_types", 64'({outlog[0].t, outlog[1].t, outlog[2].t}), 64'(6'b00_01_10));

        // rr_ptr is now 1: simultaneous single-flit packets on 0 and 2 go 2 first.
        outlog.delete();
        push(0, 2'b11); push(2, 2'b11);
        drive();
        steps(3);
        check_log("rr_after_t1", '{2, 0});

        // Single-flit packets: input 3, then input 0 a cycle later; never locks.
        outlog.delete();
        push(3, 2'b11);
        drive();
        step();
        chk("t3_nolock_a", 64'(locked_o), 64'(0));
        push(0, 2'b11);
        drive();
        step();
        chk("t3_nolock_b", 64'(locked_o), 64'(0));
        step();
        chk("t3_nolock_c", 64'(locked_o), 64'(0));
        step();
        check_log("t3_order", '{3, 0});

        // Stray BODY flits on 0 and 1 in IDLE are swallowed together.
        outlog.delete();
        push(0, 2'b01); push(1, 2'b01);
        drive();
        step();
        chk("t4_err", 64'({err_o, err_src_o}), 64'(5'b1_0011));
        chk("t4_nofwd", 64'(network_valid_o), 64'(0));
        chk("t4_consumed", 64'(srcq[0].size() + srcq[1].size()), 64'(0));
        step();
        chk("t4_err_clear", 64'(err_o), 64'(0));
        step();
        check_log("t4_none", '{});

        // Downstream stall mid-packet while input 2 raises a HEADER.
        outlog.delete();
        push(1, 2'b00); push(1, 2'b01); push(1, 2'b10);
        drive();
        step();
        network_ready_i = 1'b0;
        push(2, 2'b00); push(2, 2'b10);
        drive();
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t5_hold", network_flit_o, {32'(1), 32'(seq - 5)});
            chk("t5_owner", 64'(grant_o), 64'(4'b0010));
        end
        network_ready_i = 1'b1;
        steps(6);
        check_log("t5_order", '{1, 1, 1, 2, 2});

        // Asynchronous reset right after a HEADER transfer.
        outlog.delete();
        push(0, 2'b00); push(0, 2'b01); push(0, 2'b10);
        drive();
        step();
        #2 rst_noc = 1'b1;
        #1;
        chk("t6_valid", 64'(network_valid_o), 64'(0));
        chk("t6_flit", network_flit_o, 64'(0));
        chk("t6_lock", 64'({locked_o, grant_o}), 64'(0));
        for (int i = 0; i < NI; i++) srcq[i].delete();
        held = '0;
        model_reset();
        drive();
        #2 rst_noc = 1'b0;
        @(posedge clk_noc);
        #1;
        outlog.delete();
        push(2, 2'b00); push(2, 2'b10);
        drive();
        step();
        chk("t6_newpkt", 64'(grant_o), 64'(4'b0100));
        steps(3);
        check_log("t6_order", '{2, 2});

        // Randomized traffic with stalls, valid bubbles and framing errors.
        rand_mode = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NI; i++)
                if (srcq[i].size() < 2 && $urandom_range(0, 3) == 0) gen(i);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
